// File: rtl/ram_pkg.sv
// Shared types and constants for the byte-enabled dual-port RAM.
package ram_pkg;

   // Clear-engine / port-liveness state
   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Same-address read-during-write policies
   localparam int RDW_READ_FIRST  = 0;
   localparam int RDW_WRITE_FIRST = 1;

   // Number of byte lanes in a word
   function automatic int be_width(input int dw);
      return dw / 8;
   endfunction

endpackage

// File: rtl/ram_clear_ctrl.sv
// INIT/RUN sequencer: sweeps the array with the clear value, then opens the ports.
module ram_clear_ctrl
   import ram_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear_i,
   output logic                  clr_we_o,
   output logic [ADDR_WIDTH-1:0] clr_addr_o,
   output logic                  ready_o
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

   state_e                state_q;
   logic [ADDR_WIDTH-1:0] clr_addr_q;
   logic                  ready_q;

   // Clear sweep: one word per cycle; the counter wraps back to 0 on entering RUN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= INIT;
         clr_addr_q <= '0;
         ready_q    <= 1'b0;
      end else begin
         case (state_q)
            INIT: begin
               clr_addr_q <= clr_addr_q + 1'b1;
               if (clr_addr_q == LAST_ADDR) begin
                  state_q <= RUN;
                  ready_q <= 1'b1;
               end
            end
            RUN: begin
               if (clear_i) begin
                  state_q    <= INIT;
                  clr_addr_q <= '0;
                  ready_q    <= 1'b0;
               end
            end
            default: begin
               state_q    <= INIT;
               clr_addr_q <= '0;
               ready_q    <= 1'b0;
            end
         endcase
      end
   end

   assign clr_we_o   = (state_q == INIT);
   assign clr_addr_o = clr_addr_q;
   assign ready_o    = ready_q;

endmodule

// File: rtl/ram_dp_be.sv
// Simple dual-port RAM with byte enables, pipelined read + valid, selectable
// read-during-write policy and a clear engine that initialises the array.
module ram_dp_be
   import ram_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 16,
   parameter int                    ADDR_WIDTH  = 10,
   parameter int                    RD_LATENCY  = 1,
   parameter int                    RDW_MODE    = 0,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clear,
   output logic                         ready,
   input  logic                         wr_en,
   input  logic [ADDR_WIDTH-1:0]        wr_addr,
   input  logic [DATA_WIDTH-1:0]        wr_data,
   input  logic [be_width(DATA_WIDTH)-1:0] wr_be,
   input  logic                         rd_req,
   input  logic [ADDR_WIDTH-1:0]        rd_addr,
   output logic                         rd_valid,
   output logic [DATA_WIDTH-1:0]        rd_data
);

   localparam int BE_W  = be_width(DATA_WIDTH);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_lat
      $error("ram_dp_be: RD_LATENCY must be 1 or 2");
   end
   if (DATA_WIDTH % 8 != 0) begin : g_bad_dw
      $error("ram_dp_be: DATA_WIDTH must be a multiple of 8");
   end

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic                  clr_we;
   logic [ADDR_WIDTH-1:0] clr_addr;
   logic                  ready_w;
   logic                  wr_fire;
   logic                  rd_acc;
   logic [DATA_WIDTH-1:0] rd_word_d;
   logic                  out_vld_d;
   logic [DATA_WIDTH-1:0] out_data_d;
   logic                  rd_valid_q;
   logic [DATA_WIDTH-1:0] rd_data_q;

   ram_clear_ctrl #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_clr (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_i    (clear),
      .clr_we_o   (clr_we),
      .clr_addr_o (clr_addr),
      .ready_o    (ready_w)
   );

   // Ports are live only in RUN; a read in the clear cycle would land in INIT, so drop it
   assign wr_fire = ready_w & wr_en;
   assign rd_acc  = ready_w & rd_req & ~clear;

   // Array write: clear engine owns the port in INIT, otherwise byte-masked user write
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem_q[clr_addr] <= CLEAR_VALUE;
      end else if (wr_fire) begin
         for (int b = 0; b < BE_W; b++) begin
            if (wr_be[b]) mem_q[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   // Array read with optional write-first bypass of the enabled bytes
   always_comb begin
      rd_word_d = mem_q[rd_addr];
      if (RDW_MODE == RDW_WRITE_FIRST && wr_fire && (wr_addr == rd_addr)) begin
         for (int b = 0; b < BE_W; b++) begin
            if (wr_be[b]) rd_word_d[8*b +: 8] = wr_data[8*b +: 8];
         end
      end
   end

   if (RD_LATENCY == 2) begin : g_lat2
      logic                  s1_vld_q;
      logic [DATA_WIDTH-1:0] s1_data_q;
      logic                  flush;

      // A clear in RUN kills anything already in the pipe
      assign flush = ready_w & clear;

      // Extra array-output register stage; valid travels with its data
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
         end else begin
            s1_vld_q <= rd_acc & ~flush;
            if (rd_acc) s1_data_q <= rd_word_d;
         end
      end

      assign out_vld_d  = s1_vld_q & ~flush;
      assign out_data_d = s1_data_q;
   end else begin : g_lat1
      assign out_vld_d  = rd_acc;
      assign out_data_d = rd_word_d;
   end

   // Output stage: data only moves on a valid, otherwise it holds
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= out_vld_d;
         if (out_vld_d) rd_data_q <= out_data_d;
      end
   end

   assign ready    = ready_w;
   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_ram_dp_be.sv
// Bench for ram_dp_be: two instances (latency 1 read-first, latency 2 write-first)
// share the stimulus; a behavioural model pushes expected reads into per-instance
// queues which a negedge monitor pops when rd_valid appears.
module tb_ram_dp_be;

   localparam int          DW    = 16;
   localparam int          AW    = 4;
   localparam int          DEPTH = 16;
   localparam logic [15:0] CV    = 16'h00AA;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear = 1'b0;
   logic        wr_en = 1'b0;
   logic [3:0]  wr_addr = '0;
   logic [15:0] wr_data = '0;
   logic [1:0]  wr_be = '0;
   logic        rd_req = 1'b0;
   logic [3:0]  rd_addr = '0;

   logic        ready_a, ready_b, vld_a, vld_b;
   logic [15:0] data_a, data_b;

   always #5 clk = ~clk;

   ram_dp_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1), .RDW_MODE(0),
               .CLEAR_VALUE(CV)) dut_a (
      .clk(clk), .rst_n(rst_n), .clear(clear), .ready(ready_a),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(vld_a), .rd_data(data_a));

   ram_dp_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(2), .RDW_MODE(1),
               .CLEAR_VALUE(CV)) dut_b (
      .clk(clk), .rst_n(rst_n), .clear(clear), .ready(ready_b),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(vld_b), .rd_data(data_b));

   typedef struct {
      logic [15:0] data;
      int          due;
   } exp_t;

   exp_t        q_a[$];
   exp_t        q_b[$];
   logic [15:0] mdl [DEPTH];
   bit          m_run = 1'b0;
   int          m_clr = 0;
   logic [15:0] last_a = '0;
   logic [15:0] last_b = '0;
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: ready vs model, valid/data vs scoreboard, hold between valids
   always @(negedge clk) begin
      exp_t e;
      checks++;
      if (ready_a !== m_run || ready_b !== m_run) begin
         errors++;
         $display("FAIL ready cyc=%0d: a=%b b=%b expected %b", cyc, ready_a, ready_b, m_run);
      end
      if (q_a.size() > 0 && q_a[0].due < cyc) begin
         errors++; checks++;
         $display("FAIL missing_valid_a cyc=%0d: due=%0d data=%h", cyc, q_a[0].due, q_a[0].data);
         void'(q_a.pop_front());
      end
      if (q_b.size() > 0 && q_b[0].due < cyc) begin
         errors++; checks++;
         $display("FAIL missing_valid_b cyc=%0d: due=%0d data=%h", cyc, q_b[0].due, q_b[0].data);
         void'(q_b.pop_front());
      end
      checks++;
      if (vld_a === 1'b1) begin
         if (q_a.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid_a cyc=%0d: data=%h", cyc, data_a);
         end else if (q_a[0].due > cyc) begin
            errors++;
            $display("FAIL early_valid_a cyc=%0d: expected at cyc %0d", cyc, q_a[0].due);
         end else begin
            e = q_a.pop_front();
            last_a = e.data;
            if (data_a !== e.data) begin
               errors++;
               $display("FAIL rd_data_a cyc=%0d: got %h expected %h", cyc, data_a, e.data);
            end
         end
      end else if (vld_a !== 1'b0 || data_a !== last_a) begin
         errors++;
         $display("FAIL hold_a cyc=%0d: vld=%b data=%h expected %h", cyc, vld_a, data_a, last_a);
      end
      checks++;
      if (vld_b === 1'b1) begin
         if (q_b.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid_b cyc=%0d: data=%h", cyc, data_b);
         end else if (q_b[0].due > cyc) begin
            errors++;
            $display("FAIL early_valid_b cyc=%0d: expected at cyc %0d", cyc, q_b[0].due);
         end else begin
            e = q_b.pop_front();
            last_b = e.data;
            if (data_b !== e.data) begin
               errors++;
               $display("FAIL rd_data_b cyc=%0d: got %h expected %h", cyc, data_b, e.data);
            end
         end
      end else if (vld_b !== 1'b0 || data_b !== last_b) begin
         errors++;
         $display("FAIL hold_b cyc=%0d: vld=%b data=%h expected %h", cyc, vld_b, data_b, last_b);
      end
   end

   // One clock: push expected reads, cross the edge, update the model, return at negedge
   task automatic step();
      logic [15:0] old, mrg;
      if (rst_n && m_run && rd_req && !clear) begin
         old = mdl[rd_addr];
         mrg = old;
         if (wr_en && wr_addr == rd_addr)
            for (int b = 0; b < 2; b++) if (wr_be[b]) mrg[8*b +: 8] = wr_data[8*b +: 8];
         q_a.push_back('{old, cyc + 1});
         q_b.push_back('{mrg, cyc + 2});
      end
      @(posedge clk);
      if (rst_n) begin
         if (!m_run) begin
            mdl[m_clr] = CV;
            if (m_clr == DEPTH - 1) begin
               m_run = 1'b1;
               m_clr = 0;
            end else m_clr++;
         end else begin
            if (wr_en)
               for (int b = 0; b < 2; b++)
                  if (wr_be[b]) mdl[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
            if (clear) begin
               m_run = 1'b0;
               m_clr = 0;
               q_a.delete();
               q_b.delete();
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic drive(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                        input logic [1:0] be, input logic re, input logic [3:0] ra,
                        input logic clr);
      wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
      rd_req = re; rd_addr = ra; clear = clr;
      step();
   endtask

   task automatic idle();
      drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
   endtask

   task automatic drain();
      int n = 0;
      while ((q_a.size() != 0 || q_b.size() != 0) && n < 10) begin
         idle();
         n++;
      end
      checks++;
      if (q_a.size() != 0 || q_b.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d/%0d reads still pending", q_a.size(), q_b.size());
      end
   endtask

   // Count INIT cycles until ready; must be the full array depth
   task automatic wait_ready(input string tag);
      int n = 0;
      while (!ready_a && n < 40) begin
         step();
         n++;
      end
      checks++;
      if (n != DEPTH) begin
         errors++;
         $display("FAIL %s_init_len: %0d cycles, expected %0d", tag, n, DEPTH);
      end
   endtask

   task automatic read_all(input string tag);
      for (int a = 0; a < DEPTH; a++) drive(1'b0, '0, '0, '0, 1'b1, 4'(a), 1'b0);
      drain();
      checks++;
      if (data_a !== CV || data_b !== CV) begin
         errors++;
         $display("FAIL %s_cleared: a=%h b=%h expected %h", tag, data_a, data_b, CV);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (ready_a !== 1'b0 || ready_b !== 1'b0 || vld_a !== 1'b0 || vld_b !== 1'b0 ||
          data_a !== 16'h0 || data_b !== 16'h0) begin
         errors++;
         $display("FAIL reset_state: ready=%b%b vld=%b%b data=%h/%h expected all 0",
                  ready_a, ready_b, vld_a, vld_b, data_a, data_b);
      end
      rst_n = 1'b1;
      wait_ready("reset");
      read_all("reset");
   endtask

   task automatic test_byte_enable();
      drive(1'b1, 4'd3, 16'h1234, 2'b11, 1'b0, '0, 1'b0);
      drive(1'b1, 4'd3, 16'hABCD, 2'b10, 1'b0, '0, 1'b0);
      drive(1'b1, 4'd4, 16'hFFFF, 2'b00, 1'b1, 4'd3, 1'b0);
      drive(1'b0, '0, '0, '0, 1'b1, 4'd4, 1'b0);
      drain();
      checks++;
      if (data_a !== CV || data_b !== CV) begin
         errors++;
         $display("FAIL be_zero_noop: a=%h b=%h expected %h", data_a, data_b, CV);
      end
      drive(1'b0, '0, '0, '0, 1'b1, 4'd3, 1'b0);
      drain();
      checks++;
      if (data_a !== 16'hAB34 || data_b !== 16'hAB34) begin
         errors++;
         $display("FAIL byte_merge: a=%h b=%h expected AB34", data_a, data_b);
      end
   endtask

   task automatic test_rdw();
      drive(1'b1, 4'd5, 16'h1111, 2'b11, 1'b0, '0, 1'b0);
      drive(1'b1, 4'd5, 16'h5555, 2'b11, 1'b1, 4'd5, 1'b0);
      checks++;
      if (vld_a !== 1'b1 || data_a !== 16'h1111) begin
         errors++;
         $display("FAIL rdw_read_first: vld=%b data=%h expected 1/1111", vld_a, data_a);
      end
      drive(1'b0, '0, '0, '0, 1'b1, 4'd5, 1'b0);
      checks++;
      if (vld_a !== 1'b1 || data_a !== 16'h5555 || vld_b !== 1'b1 || data_b !== 16'h5555) begin
         errors++;
         $display("FAIL rdw_followup: a=%b/%h b=%b/%h expected 1/5555", vld_a, data_a, vld_b, data_b);
      end
      drain();
      checks++;
      if (data_b !== 16'h5555) begin
         errors++;
         $display("FAIL rdw_write_first_hold: b=%h expected 5555", data_b);
      end
   endtask

   task automatic test_back_to_back();
      for (int a = 0; a < 4; a++) drive(1'b1, 4'(a), 16'hC000 + 16'(a), 2'b11, 1'b0, '0, 1'b0);
      for (int a = 0; a < 4; a++) drive(1'b0, '0, '0, '0, 1'b1, 4'(a), 1'b0);
      drain();
      repeat (3) idle();
      checks++;
      if (data_a !== 16'hC003 || data_b !== 16'hC003) begin
         errors++;
         $display("FAIL b2b_hold: a=%h b=%h expected C003", data_a, data_b);
      end
   endtask

   task automatic test_clear();
      drive(1'b1, 4'd7, 16'h7777, 2'b11, 1'b0, '0, 1'b0);
      drive(1'b0, '0, '0, '0, 1'b1, 4'd7, 1'b0);
      drive(1'b1, 4'd9, 16'h9999, 2'b11, 1'b1, 4'd3, 1'b1);
      // Port activity during INIT must be ignored
      while (!ready_a && m_clr < DEPTH - 1) begin
         wr_en = 1'b1; wr_addr = 4'($urandom_range(0, 15)); wr_data = 16'($urandom);
         wr_be = 2'b11; rd_req = 1'b1; rd_addr = 4'($urandom_range(0, 15)); clear = 1'($urandom);
         step();
      end
      idle();
      checks++;
      if (ready_a !== 1'b1) begin
         errors++;
         $display("FAIL clear_init_len: ready=%b after %0d INIT cycles, expected 1", ready_a, DEPTH);
      end
      read_all("clear");
   endtask

   task automatic test_reset_mid_init();
      drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
      repeat (7) idle();
      #2;
      rst_n = 1'b0;
      m_run = 1'b0; m_clr = 0; q_a.delete(); q_b.delete(); last_a = '0; last_b = '0;
      #1;
      checks++;
      if (ready_a !== 1'b0 || ready_b !== 1'b0 || vld_a !== 1'b0 || vld_b !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: ready=%b%b vld=%b%b expected 0", ready_a, ready_b, vld_a, vld_b);
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      wait_ready("reinit");
      read_all("reinit");
   endtask

   task automatic test_random();
      for (int i = 0; i < 80; i++) begin
         drive(1'($urandom), 4'($urandom_range(0, 15)), 16'($urandom), 2'($urandom),
               1'($urandom), 4'($urandom_range(0, 15)), 1'b0);
      end
      drain();
      for (int a = 0; a < DEPTH; a++) drive(1'b0, '0, '0, '0, 1'b1, 4'(a), 1'b0);
      drain();
   endtask

   initial begin
      test_reset();
      test_byte_enable();
      test_rdw();
      test_back_to_back();
      test_random();
      test_clear();
      test_reset_mid_init();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
